time_unit_timebase: RTL and testbench
=====================================

# time_unit_timebase

Multi-channel simulation timebase for the time-unit lowering flow. One free-running count in precision steps (1 step = 10^PREC_EXP s) is kept as a per-channel quotient/remainder pair, one pair per module timeunit. Each channel reports its time value both truncated and rounded half-up, so a `time` and a `realtime` view exist side by side. Per-channel alarms let scheduling logic wait on a target time in its own unit. The block sits beside the elaborated design hierarchy; each module scope reads the channel matching its timeunit.

## Interface
- NUM_CH, 2, number of timeunit channels (1..8)
- WIDTH, 64, width of each channel's integer time value
- REM_W, 32, remainder width; must hold 10^9 − 1
- UNIT_EXP, {4'd2, 4'd3}, packed NUM_CH×4 bits; channel c divisor D[c] = 10^UNIT_EXP[c], range 0..9
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- tick_i  in  1  advance time by one precision step
- clear_i  in  1  synchronous return to time zero
- arm_valid_i  in  1  load an alarm target
- arm_ch_i  in  $clog2(NUM_CH) (min 1)  channel the alarm is for
- arm_time_i  in  WIDTH  target, in that channel's unit
- t_floor_o  out  NUM_CH×WIDTH  truncated time per channel
- t_round_o  out  NUM_CH×WIDTH  time rounded half-up per channel
- t_rem_o  out  NUM_CH×REM_W  remainder in precision steps, 0..D[c]−1
- alarm_o  out  NUM_CH  one-cycle alarm pulse per channel
- ovf_o  out  NUM_CH  sticky saturation flag per channel

## Operation
- Each channel holds q (WIDTH) and r (REM_W). No dividers; only increment and compare.
- On tick: if r == D−1, then r←0 and q←q+1. Otherwise r←r+1.
- t_floor = q. t_round = q + (2·r ≥ D). With D = 1, r is always 0 and t_round = q.
- Saturation:
  - A tick with q = all-ones and r = D−1 holds q and r, and sets ovf_o[c].
  - ovf_o[c] stays set until clear_i or reset.
  - If the +1 on t_round would wrap, t_round = q instead.
- clear_i sets q, r, ovf and alarm_o to 0. It does not disarm alarms.
- clear_i wins over a tick in the same cycle; that tick is dropped.
- Arming:
  - arm_valid_i loads target[arm_ch_i] and sets armed[arm_ch_i].
  - Re-arming an armed channel replaces its target.
  - arm_ch_i ≥ NUM_CH is ignored.
- Firing: while armed[c] and t_round[c] ≥ target[c], alarm_o[c] pulses for one cycle and armed[c] clears.
- Arming and firing on the same channel in the same cycle: the new arm wins. armed stays set and the new target is evaluated next cycle.
- Reset: all q, r, target, armed, alarm_o and ovf_o go to 0, and every output reads 0.

## Timing
- All outputs are registered.
- tick_i sampled high at edge n: t_floor/t_round/t_rem/ovf show the new value after edge n (cycle n+1).
- Alarm comparison uses the registered t_round and target. alarm_o rises on the edge after the first cycle in which the condition holds.
  - Armed at edge n with the target already reached: alarm_o is high in cycle n+2.
  - Tick at edge n reaches the target: alarm_o is high in cycle n+2.
- Ticks may arrive every cycle. Throughput is one step per cycle with no stalls.
- rst_n low at any point (mid-count, mid-alarm) clears state immediately. Operation resumes on the first edge after deassertion.

## Structure
- time_unit_pkg:
  - MAX_EXP = 9
  - typedef unit_exp_t (logic [3:0])
  - function pow10(unit_exp_t) returning a REM_W-bit constant
  - elaboration check that every UNIT_EXP entry ≤ MAX_EXP
- Sub-module time_unit_channel holds one q/r/target/armed/ovf set. The top is a generate loop plus arm-channel decode.

## Test plan
- UNIT_EXP={2,3}, 5670 ticks:
  - ch0 (1ns): floor 5, round 6, rem 670
  - ch1 (100ps): floor 56, round 57, rem 70
- 499 ticks → ch0 round 0. The 500th tick → ch0 round 1, floor 0.
- Arm ch1 target 5, then tick:
  - alarm_o[1] stays low through 449 ticks
  - alarm_o[1] pulses exactly once, 2 cycles after the 450th tick
  - further ticks give no pulse
- Arm ch0 target 0 right after reset → alarm_o[0] high in cycle +2 only. Arming ch7 with NUM_CH=2 has no effect.
- WIDTH=4, ch1 D=100, 1600 ticks:
  - floor 15 from tick 1500, rem 99, round 15, ovf_o[1]=1
  - further ticks change nothing
  - clear → all zero
- clear_i and tick_i together at count 123 → next cycle all zeros. Reset asserted mid-count → zeros immediately.

Source files
------------

// File: rtl/time_unit_pkg.sv
// Shared definitions for the multi-channel simulation timebase.
//   MAX_EXP    : largest supported timeunit exponent (10^9 precision steps)
//   POW_W      : width of the divisor constants produced by pow10()
//   unit_exp_t : one channel's timeunit exponent relative to the precision
//   pow10()    : 10^e as a constant, used to size each channel's divisor
package time_unit_pkg;

  localparam int MAX_EXP = 9;
  localparam int POW_W   = 32;

  typedef logic [3:0] unit_exp_t;

  function automatic logic [POW_W-1:0] pow10(input unit_exp_t e);
    logic [POW_W-1:0] v;
    v = 1;
    for (int i = 0; i < MAX_EXP; i++) begin
      if (i < int'(e)) v = v * 10;
    end
    return v;
  endfunction

endpackage

// File: rtl/time_unit_channel.sv
// One timeunit channel: quotient/remainder view of the shared precision-step
// count, a rounded (half-up) view, a sticky saturation flag and one alarm.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : advance by one precision step
//   clear      : synchronous return to time zero (target/armed untouched)
//   arm        : load arm_time as the alarm target and arm the alarm
//   arm_time   : alarm target in this channel's unit
//   t_floor    : truncated time (q)
//   t_round    : time rounded half-up, saturating at all-ones
//   t_rem      : remainder in precision steps, 0..D-1
//   alarm      : one-cycle pulse when the armed target is reached
//   ovf        : sticky flag, set by a tick at the saturation point
module time_unit_channel
  import time_unit_pkg::*;
#(
  parameter int        WIDTH    = 64,
  parameter int        REM_W    = 32,
  parameter unit_exp_t UNIT_EXP = 4'd0
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clear,
  input  logic             arm,
  input  logic [WIDTH-1:0] arm_time,
  output logic [WIDTH-1:0] t_floor,
  output logic [WIDTH-1:0] t_round,
  output logic [REM_W-1:0] t_rem,
  output logic             alarm,
  output logic             ovf
);

  localparam logic [POW_W-1:0] D_FULL = pow10(UNIT_EXP);
  localparam logic [REM_W-1:0] D_M1   = REM_W'(D_FULL - 32'd1);
  localparam logic [REM_W:0]   D_X    = (REM_W+1)'(D_FULL);

  // Round half-up: add one when 2r >= D, unless q is already all-ones.
  function automatic logic [WIDTH-1:0] round_half_up(input logic [WIDTH-1:0] q,
                                                     input logic [REM_W-1:0] r);
    logic up;
    up = ({r, 1'b0} >= D_X);
    if (up && !(&q)) return q + 1'b1;
    return q;
  endfunction

  logic [WIDTH-1:0] q_p1, q_nxt;
  logic [REM_W-1:0] r_p1, r_nxt;
  logic [WIDTH-1:0] round_p1;
  logic             ovf_p1, ovf_nxt;
  logic [WIDTH-1:0] target;
  logic             armed;
  logic             alarm_p2;
  logic             fire;

  always_comb begin
    q_nxt   = q_p1;
    r_nxt   = r_p1;
    ovf_nxt = ovf_p1;
    if (clear) begin
      q_nxt   = '0;
      r_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (tick) begin
      if (r_p1 == D_M1) begin
        // At the very last representable step the count freezes.
        if (&q_p1) begin
          ovf_nxt = 1'b1;
        end else begin
          q_nxt = q_p1 + 1'b1;
          r_nxt = '0;
        end
      end else begin
        r_nxt = r_p1 + 1'b1;
      end
    end
  end

  // Compares registered values, so the pulse lands one edge after the
  // condition first holds.
  assign fire = armed && (round_p1 >= target);

  // Stage p1: count registers and rounded view; stage p2: alarm pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p1     <= '0;
      r_p1     <= '0;
      round_p1 <= '0;
      ovf_p1   <= 1'b0;
      target   <= '0;
      armed    <= 1'b0;
      alarm_p2 <= 1'b0;
    end else begin
      q_p1     <= q_nxt;
      r_p1     <= r_nxt;
      round_p1 <= round_half_up(q_nxt, r_nxt);
      ovf_p1   <= ovf_nxt;
      if (arm) begin
        // A new arm overrides a same-cycle firing; the new target is
        // evaluated on the following cycle.
        target   <= arm_time;
        armed    <= 1'b1;
        alarm_p2 <= 1'b0;
      end else if (fire && !clear) begin
        armed    <= 1'b0;
        alarm_p2 <= 1'b1;
      end else begin
        alarm_p2 <= 1'b0;
      end
    end
  end

  assign t_floor = q_p1;
  assign t_round = round_p1;
  assign t_rem   = r_p1;
  assign alarm   = alarm_p2;
  assign ovf     = ovf_p1;

endmodule

// File: rtl/time_unit_timebase.sv
// Multi-channel simulation timebase. A single precision-step count is kept
// per timeunit channel as a quotient/remainder pair with divisor
// 10^UNIT_EXP[c]; each channel exposes truncated and rounded time, the
// remainder, an alarm pulse and a sticky saturation flag.
//   clk, rst_n   : clock, asynchronous active-low reset
//   tick_i       : advance all channels by one precision step
//   clear_i      : synchronous return to time zero (alarms stay armed)
//   arm_valid_i  : load arm_time_i as the target of channel arm_ch_i
//   arm_ch_i     : alarm channel; values >= NUM_CH are ignored
//   arm_time_i   : alarm target in that channel's unit
//   t_floor_o    : NUM_CH x WIDTH truncated time
//   t_round_o    : NUM_CH x WIDTH rounded half-up time
//   t_rem_o      : NUM_CH x REM_W remainder in precision steps
//   alarm_o      : per-channel one-cycle alarm pulse
//   ovf_o        : per-channel sticky saturation flag
module time_unit_timebase
  import time_unit_pkg::*;
#(
  parameter int                  NUM_CH   = 2,
  parameter int                  WIDTH    = 64,
  parameter int                  REM_W    = 32,
  parameter logic [NUM_CH*4-1:0] UNIT_EXP = {4'd2, 4'd3},
  localparam int                 AW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick_i,
  input  logic                    clear_i,
  input  logic                    arm_valid_i,
  input  logic [AW-1:0]           arm_ch_i,
  input  logic [WIDTH-1:0]        arm_time_i,
  output logic [NUM_CH*WIDTH-1:0] t_floor_o,
  output logic [NUM_CH*WIDTH-1:0] t_round_o,
  output logic [NUM_CH*REM_W-1:0] t_rem_o,
  output logic [NUM_CH-1:0]       alarm_o,
  output logic [NUM_CH-1:0]       ovf_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam unit_exp_t EXP_C = UNIT_EXP[c*4 +: 4];

    if (EXP_C > MAX_EXP) begin : g_bad_exp
      $error("time_unit_timebase: UNIT_EXP entry exceeds MAX_EXP");
    end

    // Out-of-range channel numbers match no channel and are dropped.
    logic arm_c;
    assign arm_c = arm_valid_i && (arm_ch_i == AW'(c));

    time_unit_channel #(
      .WIDTH    (WIDTH),
      .REM_W    (REM_W),
      .UNIT_EXP (EXP_C)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick_i),
      .clear    (clear_i),
      .arm      (arm_c),
      .arm_time (arm_time_i),
      .t_floor  (t_floor_o[c*WIDTH +: WIDTH]),
      .t_round  (t_round_o[c*WIDTH +: WIDTH]),
      .t_rem    (t_rem_o[c*REM_W +: REM_W]),
      .alarm    (alarm_o[c]),
      .ovf      (ovf_o[c])
    );
  end

endmodule

// File: tb/tb_time_unit_timebase.sv
// Directed bench for time_unit_timebase: a default instance (NUM_CH=2,
// ch0 D=1000, ch1 D=100), a WIDTH=4 instance for saturation and a NUM_CH=5
// instance whose arm channel is held at 7 (out of range).
module tb_time_unit_timebase;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        clear = 1'b0;
  logic        arm_valid = 1'b0;
  logic [0:0]  arm_ch = 1'b0;
  logic [63:0] arm_time = '0;
  logic [2:0]  arm_ch3 = 3'd7;

  logic [127:0] floor1, round1;
  logic [63:0]  rem1;
  logic [1:0]   alarm1, ovf1;

  logic [7:0]   floor2, round2;
  logic [63:0]  rem2;
  logic [1:0]   alarm2, ovf2;

  logic [319:0] floor3, round3;
  logic [159:0] rem3;
  logic [4:0]   alarm3, ovf3;

  int total = 0;
  int bad = 0;
  int early;
  int pulses;
  logic any3 = 1'b0;

  always #5 clk = ~clk;

  time_unit_timebase dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .clear_i(clear),
    .arm_valid_i(arm_valid), .arm_ch_i(arm_ch), .arm_time_i(arm_time),
    .t_floor_o(floor1), .t_round_o(round1), .t_rem_o(rem1),
    .alarm_o(alarm1), .ovf_o(ovf1)
  );

  time_unit_timebase #(.WIDTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .clear_i(clear),
    .arm_valid_i(arm_valid), .arm_ch_i(arm_ch), .arm_time_i(arm_time[3:0]),
    .t_floor_o(floor2), .t_round_o(round2), .t_rem_o(rem2),
    .alarm_o(alarm2), .ovf_o(ovf2)
  );

  time_unit_timebase #(
    .NUM_CH(5),
    .UNIT_EXP({4'd0, 4'd1, 4'd0, 4'd2, 4'd3})
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .clear_i(clear),
    .arm_valid_i(arm_valid), .arm_ch_i(arm_ch3), .arm_time_i(arm_time),
    .t_floor_o(floor3), .t_round_o(round3), .t_rem_o(rem3),
    .alarm_o(alarm3), .ovf_o(ovf3)
  );

  always @(negedge clk) if (alarm3 != '0) any3 <= 1'b1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_floor", floor1, 0);
    chk("rst_round", round1, 0);
    chk("rst_rem", rem1, 0);
    chk("rst_alarm", alarm1, 0);
    chk("rst_ovf", ovf1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Arm ch0 target 0 right after reset: pulse in cycle +2 only
    arm_valid = 1'b1; arm_ch = 1'b0; arm_time = 64'd0;
    @(negedge clk);
    arm_valid = 1'b0;
    chk("arm0_c1", alarm1, 2'b00);
    @(negedge clk);
    chk("arm0_c2", alarm1, 2'b01);
    chk("arm7_c2", alarm3, 5'b0);
    @(negedge clk);
    chk("arm0_c3", alarm1, 2'b00);

    // Rounding threshold on ch0 (D=1000)
    ticks(499);
    chk("t499_round0", round1[63:0], 0);
    chk("t499_rem0", rem1[31:0], 499);
    ticks(1);
    chk("t500_round0", round1[63:0], 1);
    chk("t500_floor0", floor1[63:0], 0);
    chk("t500_rem0", rem1[31:0], 500);
    chk("t500_d1_floor", floor3[128 +: 64], 500);
    chk("t500_d1_round", round3[128 +: 64], 500);
    chk("t500_d1_rem", rem3[64 +: 32], 0);
    chk("t500_d10_floor", floor3[192 +: 64], 50);

    // 5670 ticks total
    ticks(5170);
    chk("t5670_floor0", floor1[63:0], 5);
    chk("t5670_round0", round1[63:0], 6);
    chk("t5670_rem0", rem1[31:0], 670);
    chk("t5670_floor1", floor1[127:64], 56);
    chk("t5670_round1", round1[127:64], 57);
    chk("t5670_rem1", rem1[63:32], 70);

    // Clear back to zero
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_floor", floor1, 0);
    chk("clr_round", round1, 0);

    // Clear together with a tick at count 123
    ticks(123);
    chk("t123_floor1", floor1[127:64], 1);
    chk("t123_rem1", rem1[63:32], 23);
    clear = 1'b1; tick = 1'b1;
    @(negedge clk);
    clear = 1'b0; tick = 1'b0;
    chk("clrtick_floor", floor1, 0);
    chk("clrtick_round", round1, 0);
    chk("clrtick_rem", rem1, 0);

    // Alarm on ch1 at target 5 (reached at count 450)
    arm_valid = 1'b1; arm_ch = 1'b1; arm_time = 64'd5;
    @(negedge clk);
    arm_valid = 1'b0;
    early = 0;
    for (int i = 0; i < 449; i++) begin
      tick = 1'b1;
      @(negedge clk);
      if (alarm1[1]) early++;
    end
    tick = 1'b0;
    chk("alarm1_early", early, 0);
    chk("t449_round1", round1[127:64], 4);
    ticks(1);
    chk("alarm1_c1", alarm1[1], 1'b0);
    @(negedge clk);
    chk("alarm1_c2", alarm1[1], 1'b1);
    @(negedge clk);
    chk("alarm1_c3", alarm1[1], 1'b0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick = 1'b1;
      @(negedge clk);
      if (alarm1[1]) pulses++;
    end
    tick = 1'b0;
    chk("alarm1_again", pulses, 0);

    // WIDTH=4 saturation on ch1 (D=100)
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("w4_clr_ovf", ovf2, 0);
    ticks(1500);
    chk("w4_t1500_floor", floor2[7:4], 15);
    chk("w4_t1500_rem", rem2[63:32], 0);
    ticks(99);
    chk("w4_t1599_rem", rem2[63:32], 99);
    chk("w4_t1599_round", round2[7:4], 15);
    chk("w4_t1599_ovf", ovf2[1], 1'b0);
    ticks(1);
    chk("w4_t1600_floor", floor2[7:4], 15);
    chk("w4_t1600_rem", rem2[63:32], 99);
    chk("w4_t1600_round", round2[7:4], 15);
    chk("w4_t1600_ovf", ovf2[1], 1'b1);
    ticks(50);
    chk("w4_hold_floor", floor2[7:4], 15);
    chk("w4_hold_rem", rem2[63:32], 99);
    chk("w4_hold_ovf", ovf2[1], 1'b1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("w4_clr_floor", floor2, 0);
    chk("w4_clr_round", round2, 0);
    chk("w4_clr_rem", rem2, 0);
    chk("w4_clr_ovf2", ovf2, 0);

    // Asynchronous reset mid-count
    ticks(37);
    chk("t37_rem0", rem1[31:0], 37);
    rst_n = 1'b0;
    #1;
    chk("arst_floor", floor1, 0);
    chk("arst_rem", rem1, 0);
    chk("arst_rem3", rem3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(3);
    chk("post_rst_rem0", rem1[31:0], 3);

    chk("arm7_never", any3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
